// File: rtl/rf_seq_pkg.sv
// Shared types and constants for the rf_seq burst sequencer.
package rf_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_e;

   localparam logic OP_WR = 1'b0;
   localparam logic OP_RD = 1'b1;

endpackage

// File: rtl/rf_seq_ctr.sv
// Loadable row pointer / remaining-beat counter for rf_seq.
// ptr wraps modulo numRow; last flags the final beat of a burst (rem == 0).
module rf_seq_ctr #(
   parameter int numRow     = 16,
   parameter int numRowAddr = 4
) (
   input  logic                  CLK,
   input  logic                  RSTB,
   input  logic                  load,
   input  logic [numRowAddr-1:0] addr,
   input  logic [numRowAddr-1:0] len,
   input  logic                  step,
   output logic [numRowAddr-1:0] ptr,
   output logic                  last
);

   logic [numRowAddr-1:0] ptr_q, ptr_d;
   logic [numRowAddr-1:0] rem_q, rem_d;

   // Next pointer/remaining count: load on command, advance on non-final beats.
   always_comb begin
      ptr_d = ptr_q;
      rem_d = rem_q;
      if (load) begin
         ptr_d = addr;
         rem_d = len;
      end else if (step && (rem_q != '0)) begin
         ptr_d = (ptr_q == numRowAddr'(numRow - 1)) ? '0 : ptr_q + 1'b1;
         rem_d = rem_q - 1'b1;
      end
   end

   // Counter registers, cleared by asynchronous reset.
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         ptr_q <= '0;
         rem_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         rem_q <= rem_d;
      end
   end

   assign ptr  = ptr_q;
   assign last = (rem_q == '0);

endmodule

// File: rtl/rf_seq.sv
// Burst sequencer in front of the 16x8 register-file macro: turns
// valid/ready write/read burst commands into RF chip/write enables.
module rf_seq
   import rf_seq_pkg::*;
#(
   parameter int numRow     = 16,
   parameter int numBit     = 8,
   parameter int numRowAddr = 4
) (
   input  logic                  CLK,
   input  logic                  RSTB,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_op,
   input  logic [numRowAddr-1:0] cmd_addr,
   input  logic [numRowAddr-1:0] cmd_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [numBit-1:0]     wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [numBit-1:0]     rd_data,
   output logic                  done,
   output logic                  busy,
   output logic                  CEB,
   output logic                  WEB,
   output logic [numRowAddr-1:0] A,
   output logic [numBit-1:0]     D,
   output logic [numBit-1:0]     BWEB,
   input  logic [numBit-1:0]     Q
);

   state_e                state_q, state_d;
   logic                  done_q, done_d;
   logic                  cmd_hs;
   logic                  beat;
   logic                  last;
   logic [numRowAddr-1:0] ptr;

   assign cmd_hs = (state_q == IDLE) && cmd_valid;
   assign beat   = ((state_q == WRITE) && wr_valid) || ((state_q == READ) && rd_ready);

   rf_seq_ctr #(
      .numRow     (numRow),
      .numRowAddr (numRowAddr)
   ) u_ctr (
      .CLK  (CLK),
      .RSTB (RSTB),
      .load (cmd_hs),
      .addr (cmd_addr),
      .len  (cmd_len),
      .step (beat),
      .ptr  (ptr),
      .last (last)
   );

   // Next state and end-of-burst pulse.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) state_d = (cmd_op == OP_RD) ? READ : WRITE;
         end
         WRITE, READ: begin
            if (beat && last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM registers, cleared by asynchronous reset (drops any burst in flight).
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // Handshake outputs and combinational RF drive.
   always_comb begin
      cmd_ready = (state_q == IDLE);
      wr_ready  = (state_q == WRITE);
      rd_valid  = (state_q == READ);
      busy      = (state_q != IDLE);
      done      = done_q;
      CEB       = (state_q == IDLE);
      WEB       = !((state_q == WRITE) && wr_valid);
      BWEB      = (state_q == WRITE) ? '0 : '1;
      A         = ptr;
      D         = wr_data;
      rd_data   = Q;
   end

endmodule
